// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl: services one line miss by writing back a dirty victim, then refilling the line
// through the bridge's burst port and returning it to the cache as a single-cycle response.
module cache_miss_ctrl #(
   parameter int LINE_WORDS = 16,
   parameter int OFF_W      = 6
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [31:0]             req_addr,
   input  logic                    req_dirty,
   input  logic [31:0]             victim_addr,
   input  logic [LINE_WORDS*32-1:0] victim_line,
   output logic                    resp_valid,
   output logic [LINE_WORDS*32-1:0] resp_line,
   output logic                    resp_err,
   output logic                    en,
   output logic                    wen,
   output logic [31:0]             addr,
   output logic [31:0]             write_data,
   input  logic [31:0]             read_data,
   input  logic                    addr_ok,
   input  logic                    data_ok,
   input  logic                    burst_ok
);
   localparam int IW = $clog2(LINE_WORDS);
   localparam int CW = IW + 1;
   localparam logic [31:0] LINE_MASK = ~((32'd1 << OFF_W) - 32'd1);
   typedef enum logic [2:0] {IDLE, WB_REQ, WB_DATA, WB_RESP, RF_REQ, RF_DATA, DONE} state_t;
   state_t state, nxt;
   logic [CW-1:0] wcnt, rcnt;
   logic [31:0] miss_addr, vict_addr;
   logic [LINE_WORDS-1:0][31:0] wb_buf, rf_buf;
   logic accept, rd_beat;
   assign accept = (state == IDLE) && req_valid;
   assign rd_beat = (state == RF_DATA) && data_ok && (rcnt != CW'(LINE_WORDS));
   assign resp_line = rf_buf;
   always_comb begin
      nxt = state;
      req_ready = 1'b0;
      resp_valid = 1'b0;
      en = 1'b0;
      wen = 1'b0;
      addr = 32'd0;
      write_data = 32'd0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            nxt = req_valid ? (req_dirty ? WB_REQ : RF_REQ) : IDLE;
         end
         WB_REQ: begin
            en = 1'b1;
            wen = 1'b1;
            addr = vict_addr;
            nxt = addr_ok ? WB_DATA : WB_REQ;
         end
         WB_DATA: begin
            wen = 1'b1;
            write_data = wb_buf[wcnt[IW-1:0]];
            nxt = (data_ok && wcnt == CW'(LINE_WORDS-1)) ? WB_RESP : WB_DATA;
         end
         WB_RESP: begin
            wen = 1'b1;
            nxt = burst_ok ? RF_REQ : WB_RESP;
         end
         RF_REQ: begin
            en = 1'b1;
            addr = miss_addr;
            nxt = addr_ok ? RF_DATA : RF_REQ;
         end
         RF_DATA: nxt = burst_ok ? DONE : RF_DATA;
         DONE: begin
            resp_valid = 1'b1;
            nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         wcnt <= '0;
         rcnt <= '0;
         resp_err <= 1'b0;
         miss_addr <= 32'd0;
         vict_addr <= 32'd0;
      end else begin
         state <= nxt;
         if (accept) begin
            miss_addr <= req_addr & LINE_MASK;
            vict_addr <= victim_addr & LINE_MASK;
         end
         if (state == WB_DATA && data_ok)
            wcnt <= (wcnt == CW'(LINE_WORDS-1)) ? '0 : wcnt + 1'b1;
         if (rd_beat)
            rcnt <= rcnt + 1'b1;
         // a beat arriving with burst_ok still counts toward the final length
         if (state == RF_DATA && burst_ok)
            resp_err <= (rcnt + CW'(rd_beat)) != CW'(LINE_WORDS);
         if (state == DONE) begin
            wcnt <= '0;
            rcnt <= '0;
            resp_err <= 1'b0;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (accept)
         wb_buf <= victim_line;
      if (rd_beat)
         rf_buf[rcnt[IW-1:0]] <= read_data;
   end
endmodule

// File: tb/tb_cache_miss_ctrl.sv
// tb_cache_miss_ctrl: directed miss scenarios against a scripted bridge; a negedge monitor
// checks bursts, write-back words and responses against queued expectations.
module tb_cache_miss_ctrl;
   localparam int LW = 16;
   typedef struct {logic wen; logic [31:0] addr;} burst_t;
   typedef struct {logic [LW*32-1:0] line; logic [LW-1:0] mask; logic err;} resp_t;
   logic clk = 1'b0, rstn = 1'b0;
   logic req_valid = 1'b0, req_ready, req_dirty = 1'b0;
   logic [31:0] req_addr = '0, victim_addr = '0;
   logic [LW*32-1:0] victim_line = '0, resp_line;
   logic resp_valid, resp_err, en, wen;
   logic [31:0] addr, write_data, read_data = '0;
   logic addr_ok = 1'b0, data_ok = 1'b0, burst_ok = 1'b0;
   int tests = 0, fails = 0;
   burst_t exp_burst[$];
   logic [31:0] exp_wdata[$];
   resp_t exp_resp[$];
   logic prev_rv = 1'b0;

   cache_miss_ctrl #(.LINE_WORDS(LW), .OFF_W(6)) dut (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_dirty(req_dirty), .victim_addr(victim_addr),
      .victim_line(victim_line), .resp_valid(resp_valid), .resp_line(resp_line),
      .resp_err(resp_err), .en(en), .wen(wen), .addr(addr), .write_data(write_data),
      .read_data(read_data), .addr_ok(addr_ok), .data_ok(data_ok), .burst_ok(burst_ok));

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s got %h exp %h", n, a, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      logic [LW*32-1:0] m;
      resp_t r;
      burst_t b;
      if (en && addr_ok) begin
         if (exp_burst.size() == 0) chk("unexpected_burst", addr, 32'hFFFF_FFFF);
         else begin
            b = exp_burst.pop_front();
            chk("burst_addr", addr, b.addr);
            chk("burst_wen", {31'd0, wen}, {31'd0, b.wen});
         end
      end
      if (!en && wen && data_ok) begin
         if (exp_wdata.size() == 0) chk("unexpected_wbeat", write_data, 32'hFFFF_FFFF);
         else chk("write_data", write_data, exp_wdata.pop_front());
      end
      if (prev_rv) chk("resp_pulse", {31'd0, resp_valid}, 32'd0);
      if (resp_valid) begin
         if (exp_resp.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
         else begin
            r = exp_resp.pop_front();
            for (int k = 0; k < LW; k++) m[k*32 +: 32] = r.mask[k] ? 32'hFFFF_FFFF : 32'd0;
            tests++;
            if ((resp_line & m) !== (r.line & m)) begin
               fails++;
               $display("FAIL resp_line got %h exp %h", resp_line & m, r.line & m);
            end
            chk("resp_err", {31'd0, resp_err}, {31'd0, r.err});
         end
      end
      prev_rv <= resp_valid;
   end

   task automatic wait_en(input string n);
      for (int k = 0; k < 20 && !en; k++) tick();
      chk(n, {31'd0, en}, 32'd1);
   endtask

   task automatic addr_hs();
      addr_ok = 1'b0;
      tick();
      chk("en_hold", {31'd0, en}, 32'd1);
      addr_ok = 1'b1;
      tick();
      addr_ok = 1'b0;
   endtask

   task automatic run_miss(input logic [31:0] raddr, input logic [31:0] rexp, input logic dirty,
                           input logic [31:0] vaddr, input logic [31:0] vexp, input logic [31:0] wbase,
                           input logic [31:0] rbase, input int nbeats, input logic coincide,
                           input logic bp, input logic err);
      resp_t r;
      for (int k = 0; k < 20 && !req_ready; k++) tick();
      chk("req_ready", {31'd0, req_ready}, 32'd1);
      r.mask = '0;
      r.line = '0;
      r.err = err;
      for (int i = 0; i < nbeats && i < LW; i++) begin
         r.mask[i] = 1'b1;
         r.line[i*32 +: 32] = rbase + i;
      end
      if (dirty) begin
         exp_burst.push_back('{1'b1, vexp});
         for (int i = 0; i < LW; i++) exp_wdata.push_back(wbase + i);
      end
      exp_burst.push_back('{1'b0, rexp});
      exp_resp.push_back(r);
      req_valid = 1'b1;
      req_addr = raddr;
      req_dirty = dirty;
      victim_addr = vaddr;
      for (int i = 0; i < LW; i++) victim_line[i*32 +: 32] = wbase + i;
      tick();
      req_valid = 1'b0;
      req_addr = 32'hDEAD_BEEF;
      victim_addr = 32'hDEAD_BEEF;
      victim_line = '1;
      if (dirty) begin
         wait_en("wb_en");
         addr_hs();
         for (int i = 0; i < LW; i++) begin
            if (bp) for (int g = $urandom_range(0, 3); g > 0; g--) begin
               tick();
               chk("wd_hold", write_data, wbase + i);
            end
            data_ok = 1'b1;
            tick();
            data_ok = 1'b0;
         end
         chk("wb_en_low", {31'd0, en}, 32'd0);
         burst_ok = 1'b1;
         tick();
         burst_ok = 1'b0;
      end
      wait_en("rf_en");
      addr_hs();
      for (int i = 0; i < nbeats; i++) begin
         if (bp) for (int g = $urandom_range(0, 3); g > 0; g--) tick();
         read_data = rbase + i;
         data_ok = 1'b1;
         burst_ok = coincide && (i == nbeats - 1);
         tick();
         data_ok = 1'b0;
         burst_ok = 1'b0;
         read_data = 32'h5555_5555;
      end
      if (!coincide) begin
         burst_ok = 1'b1;
         tick();
         burst_ok = 1'b0;
      end
      for (int k = 0; k < 20 && exp_resp.size() != 0; k++) tick();
      chk("resp_seen", exp_resp.size(), 32'd0);
      tick();
   endtask

   initial begin
      #1;
      chk("rst_en", {31'd0, en}, 32'd0);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      tick();
      rstn = 1'b1;
      tick();
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_wen", {31'd0, wen}, 32'd0);
      chk("rst_addr", addr, 32'd0);
      chk("rst_wdata", write_data, 32'd0);
      chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
      run_miss(32'h1000_0234, 32'h1000_0200, 1'b0, 32'h0, 32'h0, 32'h0, 32'hA0, 16, 1'b0, 1'b0, 1'b0);
      run_miss(32'h3000_007C, 32'h3000_0040, 1'b1, 32'h2000_0047, 32'h2000_0040, 32'h100, 32'h200, 16, 1'b0, 1'b0, 1'b0);
      run_miss(32'h4000_0001, 32'h4000_0000, 1'b1, 32'h5000_FFFF, 32'h5000_FFC0, 32'h300, 32'h400, 16, 1'b0, 1'b1, 1'b0);
      run_miss(32'h6000_0100, 32'h6000_0100, 1'b0, 32'h0, 32'h0, 32'h0, 32'h500, 12, 1'b0, 1'b0, 1'b1);
      run_miss(32'h7000_00FF, 32'h7000_00C0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h600, 16, 1'b1, 1'b0, 1'b0);
      exp_burst.push_back('{1'b1, 32'h9000_0080});
      for (int i = 0; i < 5; i++) exp_wdata.push_back(32'h800 + i);
      req_valid = 1'b1;
      req_addr = 32'h9000_1000;
      req_dirty = 1'b1;
      victim_addr = 32'h9000_0088;
      for (int i = 0; i < LW; i++) victim_line[i*32 +: 32] = 32'h800 + i;
      tick();
      req_valid = 1'b0;
      wait_en("wb_en_rst");
      addr_hs();
      for (int i = 0; i < 5; i++) begin
         data_ok = 1'b1;
         tick();
         data_ok = 1'b0;
      end
      #2 rstn = 1'b0;
      #1;
      chk("midrst_en", {31'd0, en}, 32'd0);
      chk("midrst_wen", {31'd0, wen}, 32'd0);
      tick();
      rstn = 1'b1;
      #1;
      chk("postrst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("postrst_en", {31'd0, en}, 32'd0);
      chk("postrst_wdata", write_data, 32'd0);
      tick();
      run_miss(32'h8000_0010, 32'h8000_0000, 1'b0, 32'h0, 32'h0, 32'h0, 32'h700, 16, 1'b0, 1'b0, 1'b0);
      chk("left_bursts", exp_burst.size(), 32'd0);
      chk("left_wdata", exp_wdata.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule
